// File: rtl/qnet_dbg_trace_rd.sv
// QNET command-state debug trace reader: detects history shifts, queues the newest
// state code (optionally timestamped when QNET_DBG_TS_EN is defined) into a FWFT stream FIFO.
module qnet_dbg_trace_rd #(
  parameter int DEPTH = 16
) (
  input  logic                       st_clk_i,
  input  logic                       st_rst_i,
  input  logic                       enable_i,
  input  logic                       clear_i,
  input  logic                       freeze_on_err_i,
  input  logic [31:0]                debug_dt_i,
  output logic [31:0]                m_tdata_o,
  output logic                       m_tvalid_o,
  input  logic                       m_tready_i,
  output logic [$clog2(DEPTH):0]     fill_o,
  output logic [15:0]                drop_cnt_o,
  output logic                       gap_o,
  output logic                       err_o,
  output logic [1:0]                 state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [29:0] WRITER_RST_WORD = 30'h00FB_EFBE;
  localparam logic [5:0]  ST_ERROR_CODE   = 6'd63;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [29:0]     prev_q;
  logic [FW-1:0]   fill_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [31:0]     mem_q [DEPTH];
  logic [15:0]     drop_q;
  logic            gap_q, err_q;
  logic [25:0]     ts_val;

  logic       shift, writer_rst, push_req, gap_hit;
  logic       full, empty, pop, push_ok, drop;
  logic [5:0] code;

  // Bits [31:30] of the debug word are defined as zero and carry nothing.
  logic unused_hi;
  assign unused_hi = &{1'b0, debug_dt_i[31:30]};

  assign code       = debug_dt_i[29:24];
  assign shift      = (debug_dt_i[29:0] != prev_q);
  assign writer_rst = (debug_dt_i[29:0] == WRITER_RST_WORD);
  assign push_req   = shift && !writer_rst && (state_q == ST_RUN);
  // A consistent shift moves the old [29:6] down into the new [23:0].
  assign gap_hit    = push_req && (debug_dt_i[23:0] != prev_q[29:6]);

  assign full    = (fill_q == FW'(DEPTH));
  assign empty   = (fill_q == '0);
  assign pop     = !empty && m_tready_i;
  assign push_ok = push_req && (!full || pop) && !clear_i;
  assign drop    = push_req && full && !pop && !clear_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OFF:    if (enable_i) state_d = ST_RUN;
      ST_RUN: begin
        if (!enable_i)
          state_d = ST_OFF;
        else if (push_ok && code == ST_ERROR_CODE && freeze_on_err_i)
          state_d = ST_FROZEN;
      end
      ST_FROZEN: if (!enable_i) state_d = ST_OFF;
      default:   state_d = ST_OFF;
    endcase
    if (clear_i) state_d = ST_OFF;
  end

  always_ff @(posedge st_clk_i) begin
    if (st_rst_i) begin
      state_q <= ST_OFF;
      prev_q  <= WRITER_RST_WORD;
    end else begin
      state_q <= state_d;
      prev_q  <= debug_dt_i[29:0];
    end
  end

`ifdef QNET_DBG_TS_EN
  // Counter follows the next state so the first RUN cycle already reads 1.
  logic [25:0] ts_q;
  always_ff @(posedge st_clk_i) begin
    if (st_rst_i)               ts_q <= '0;
    else if (state_d == ST_OFF) ts_q <= '0;
    else                        ts_q <= ts_q + 26'd1;
  end
  assign ts_val = ts_q;
`else
  assign ts_val = '0;
`endif

  // NOTE: the storage array has no reset; validity is tracked by fill/pointers only.
  always_ff @(posedge st_clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= {ts_val, code};
  end

  always_ff @(posedge st_clk_i) begin
    if (st_rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   fill_q <= fill_q + FW'(1);
        2'b01:   fill_q <= fill_q - FW'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  always_ff @(posedge st_clk_i) begin
    if (st_rst_i || clear_i) begin
      drop_q <= '0;
      gap_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (gap_hit) gap_q <= 1'b1;
      if (push_ok && code == ST_ERROR_CODE) err_q <= 1'b1;
    end
  end

  assign m_tvalid_o = !empty;
  assign m_tdata_o  = m_tvalid_o ? mem_q[rd_ptr_q] : '0;
  assign fill_o     = fill_q;
  assign drop_cnt_o = drop_q;
  assign gap_o      = gap_q;
  assign err_o      = err_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_qnet_dbg_trace_rd.sv
// Directed bench for qnet_dbg_trace_rd: table of per-cycle vectors plus
// hand-written sequences for FIFO full/drop, full-with-pop and freeze-on-error.
module tb_qnet_dbg_trace_rd;
  localparam int DEPTH = 16;
  localparam int FW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] W0 = 32'h00FB_EFBE;

  logic          st_clk_i = 1'b0;
  logic          st_rst_i, enable_i, clear_i, freeze_on_err_i, m_tready_i;
  logic [31:0]   debug_dt_i, m_tdata_o;
  logic          m_tvalid_o, gap_o, err_o;
  logic [FW-1:0] fill_o;
  logic [15:0]   drop_cnt_o;
  logic [1:0]    state_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] cur;

  qnet_dbg_trace_rd #(.DEPTH(DEPTH)) dut (
    .st_clk_i(st_clk_i), .st_rst_i(st_rst_i), .enable_i(enable_i), .clear_i(clear_i),
    .freeze_on_err_i(freeze_on_err_i), .debug_dt_i(debug_dt_i), .m_tdata_o(m_tdata_o),
    .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .fill_o(fill_o),
    .drop_cnt_o(drop_cnt_o), .gap_o(gap_o), .err_o(err_o), .state_o(state_o)
  );

  always #5 st_clk_i = ~st_clk_i;

  typedef struct {
    logic en, clr, frz, rdy;
    logic [31:0] dt;
    logic vld;
    logic [31:0] data;
    int fill;
    logic gap, err;
    logic [1:0] st;
    int drop;
  } vec_t;
  vec_t vq[$];

  task automatic tick();
    @(posedge st_clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected stream entry; the timestamp field is zero when the counter is not built.
  function automatic logic [31:0] ent(input int ts, input int code);
    logic [31:0] t, c;
    t = ts;
    c = code;
`ifdef QNET_DBG_TS_EN
    return {t[25:0], c[5:0]};
`else
    return {26'd0, c[5:0]};
`endif
  endfunction

  // Writer-consistent shift: new code enters at the top, history moves down one field.
  task automatic sh(input int code);
    logic [31:0] c;
    c = code;
    cur = {2'b00, c[5:0], cur[29:6]};
  endtask

  task automatic add(input logic en, clr, rdy, input logic [31:0] dt, input logic vld,
                     input logic [31:0] data, input int fill, input logic gap,
                     input logic [1:0] st);
    vec_t v;
    v.en = en; v.clr = clr; v.frz = 1'b0; v.rdy = rdy; v.dt = dt;
    v.vld = vld; v.data = data; v.fill = fill; v.gap = gap; v.err = 1'b0;
    v.st = st; v.drop = 0;
    vq.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    st_rst_i = 1'b1; enable_i = 1'b0; clear_i = 1'b0; freeze_on_err_i = 1'b0;
    m_tready_i = 1'b0; debug_dt_i = W0;

    // Vector table; each row is the input of one cycle and the outputs after its edge.
    cur = W0;
    add(1, 0, 1, cur, 0, 0,          0, 0, 1);
    sh(1);
    add(1, 0, 1, cur, 1, ent(1, 1),  1, 0, 1);
    add(1, 0, 1, cur, 0, 0,          0, 0, 1);
    sh(5);
    add(1, 0, 1, cur, 1, ent(3, 5),  1, 0, 1);
    sh(7);
    add(1, 0, 1, cur, 1, ent(4, 7),  1, 0, 1);
    add(1, 0, 1, cur, 0, 0,          0, 0, 1);
    sh(8); sh(9);
    add(1, 0, 1, cur, 1, ent(6, 9),  1, 1, 1);
    add(1, 0, 1, cur, 0, 0,          0, 1, 1);
    cur = W0;
    add(1, 0, 1, cur, 0, 0,          0, 1, 1);
    add(0, 1, 1, cur, 0, 0,          0, 0, 0);
    sh(6);
    add(0, 0, 1, cur, 0, 0,          0, 0, 0);
    sh(3);
    add(1, 0, 1, cur, 0, 0,          0, 0, 1);
    sh(4);
    add(1, 0, 1, cur, 1, ent(1, 4),  1, 0, 1);
    add(0, 0, 1, cur, 0, 0,          0, 0, 0);

    repeat (2) tick();
    st_rst_i = 1'b0;
    check("rst_valid", m_tvalid_o, 0);
    check("rst_data",  m_tdata_o, 0);
    check("rst_fill",  fill_o, 0);
    check("rst_drop",  drop_cnt_o, 0);
    check("rst_gap",   gap_o, 0);
    check("rst_err",   err_o, 0);
    check("rst_state", state_o, 0);

    foreach (vq[i]) begin
      enable_i = vq[i].en; clear_i = vq[i].clr; freeze_on_err_i = vq[i].frz;
      m_tready_i = vq[i].rdy; debug_dt_i = vq[i].dt;
      tick();
      check($sformatf("v%0d_valid", i), m_tvalid_o, vq[i].vld);
      if (vq[i].vld) check($sformatf("v%0d_data", i), m_tdata_o, vq[i].data);
      check($sformatf("v%0d_fill", i),  fill_o, vq[i].fill);
      check($sformatf("v%0d_gap", i),   gap_o, vq[i].gap);
      check($sformatf("v%0d_err", i),   err_o, vq[i].err);
      check($sformatf("v%0d_state", i), state_o, vq[i].st);
      check($sformatf("v%0d_drop", i),  drop_cnt_o, vq[i].drop);
    end
    clear_i = 1'b0;

    // Overflow: DEPTH+3 shifts with the consumer stalled, then drain in order.
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    enable_i = 1'b1; m_tready_i = 1'b0; tick();
    for (int k = 0; k < DEPTH + 3; k++) begin
      sh(k + 1); debug_dt_i = cur; tick();
    end
    check("ovf_fill",  fill_o, DEPTH);
    check("ovf_drop",  drop_cnt_o, 3);
    check("ovf_gap",   gap_o, 0);
    m_tready_i = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("ovf_valid%0d", k), m_tvalid_o, 1);
      check($sformatf("ovf_data%0d", k), m_tdata_o, ent(k + 1, k + 1));
      tick();
    end
    check("ovf_empty", m_tvalid_o, 0);
    check("ovf_fill0", fill_o, 0);

    // Full FIFO with a pop and a push in the same cycle.
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    check("clr_drop", drop_cnt_o, 0);
    check("clr_state", state_o, 0);
    m_tready_i = 1'b0; tick();
    for (int k = 0; k < DEPTH; k++) begin
      sh(20 + k); debug_dt_i = cur; tick();
    end
    check("fp_fill_full", fill_o, DEPTH);
    sh(40); debug_dt_i = cur; m_tready_i = 1'b1; tick();
    m_tready_i = 1'b0;
    check("fp_fill", fill_o, DEPTH);
    check("fp_drop", drop_cnt_o, 0);
    m_tready_i = 1'b1;
    for (int k = 1; k < DEPTH; k++) begin
      check($sformatf("fp_data%0d", k), m_tdata_o, ent(k + 1, 20 + k));
      tick();
    end
    check("fp_last", m_tdata_o, ent(DEPTH + 1, 40));
    tick();
    check("fp_empty", m_tvalid_o, 0);

    // Freeze on error code, then disable, then reset with an entry queued.
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    m_tready_i = 1'b0; freeze_on_err_i = 1'b1; tick();
    sh(63); debug_dt_i = cur; tick();
    check("frz_err",   err_o, 1);
    check("frz_state", state_o, 2);
    check("frz_data",  m_tdata_o, ent(1, 63));
    sh(10); debug_dt_i = cur; tick();
    check("frz_fill",  fill_o, 1);
    enable_i = 1'b0; tick();
    check("frz_off",   state_o, 0);
    check("frz_err_sticky", err_o, 1);
    st_rst_i = 1'b1; tick(); st_rst_i = 1'b0;
    check("mrst_fill",  fill_o, 0);
    check("mrst_valid", m_tvalid_o, 0);
    check("mrst_err",   err_o, 0);
    check("mrst_state", state_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
